instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage upstream of the branch/compare execute stage. Owns the program counter and
//   reads one instruction word per fetch from the shared 32x32 unified memory. Decodes the
//   fixed instruction fields and presents them, with their PC, over a valid/ready handshake.
//   Accepts PC redirects (taken branch or jump) from the execute stage.
// PARAMETERS
//   ADDR_W       5       PC / memory address width (32-word memory)
//   DATA_W       32      instruction word width
//   RESET_PC     0       PC value loaded on reset
//   HALT_OPCODE  6'd63   opcode that stops fetching once it has been handed off
// PORTS
//   clk             in   1        single clock; all state changes on posedge
//   reset           in   1        synchronous, active-high
//   mem_rd_en       out  1        memory read strobe
//   mem_addr        out  ADDR_W   memory read address
//   mem_rdata       in   DATA_W   read data, valid on the cycle after mem_rd_en
//   redirect_valid  in   1        execute stage requests a PC change
//   redirect_pc     in   ADDR_W   target PC, already computed by execute
//   out_valid       out  1        decoded instruction available
//   out_ready       in   1        execute stage accepts this cycle
//   out_instr       out  DATA_W   raw instruction word
//   out_pc          out  ADDR_W   address the word was fetched from
//   out_opcode      out  6        instr[31:26]
//   out_rd          out  5        instr[25:21]
//   out_rs          out  5        instr[20:16]
//   out_rt          out  5        instr[15:11]
//   out_shamt       out  5        instr[10:6]
//   out_func        out  6        instr[5:0]
//   out_imm         out  16       instr[15:0], unextended
//   out_jaddr       out  26       instr[25:0]
//   halted          out  1        fetch stopped on HALT_OPCODE
// BEHAVIOUR
//   Reset: pc=RESET_PC, state=S_ISSUE, out_valid=0, mem_rd_en=0, halted=0, out_* regs=0.
//   The field outputs are combinational slices of the registered out_instr.
//   FSM:
//   - S_ISSUE: mem_rd_en=1 and mem_addr=pc for one cycle -> S_CAPT.
//   - S_CAPT: latch mem_rdata into out_instr, latch pc into out_pc, set out_valid=1,
//     pc<=pc+1 -> S_HOLD.
//   - S_HOLD: hold all outputs stable while out_valid && !out_ready.
//     On handshake: out_valid<=0. If opcode==HALT_OPCODE, go to S_HALT and set halted=1;
//     otherwise go to S_ISSUE.
//   - S_HALT: no reads are issued. Leave only on redirect or reset.
//   Latency: issue to out_valid is 2 cycles. Peak throughput is 1 instruction per 3 cycles.
//   PC increments modulo 2^ADDR_W, so 31+1 wraps to 0.
//   Redirect (any state): pc<=redirect_pc, out_valid<=0, halted<=0, next state S_ISSUE.
//   - A read in flight in S_CAPT is discarded.
//   - Redirect has priority over a handshake in the same cycle; that word counts as not
//     consumed (wrong path).
//   - Redirect in the same cycle as reset: reset wins.
//   mem_rd_en is never asserted in S_CAPT, S_HOLD or S_HALT.
//   Reset asserted mid-operation: discard everything and restart at RESET_PC.
// STRUCTURE
//   - cpu_defs.vh: field bit positions, opcode localparams (12..24 branch/jump group,
//     HALT_OPCODE) and the state encodings, shared with the execute stage.
//   - Sub-module instr_field_decode: purely combinational slicer from a word to its fields,
//     reused by execute.
// TESTING
//   1. Reset, mem[0]=32'h3BFD0001 -> mem_addr=0 at cycle 1; out_valid at cycle 2 with
//      opcode=14, rd=31, rs=29, imm=1, out_pc=0.
//   2. Hold out_ready=0 for 5 cycles -> outputs stable, no mem_rd_en; then ready=1 ->
//      next fetch from addr 1.
//   3. Redirect to 9 while in S_CAPT for addr 4 -> word 4 never presented; next
//      out_pc=9.
//   4. Redirect and handshake in the same cycle -> out_valid drops; next out_pc =
//      redirect_pc.
//   5. Start at pc=31 and run straight-line -> out_pc sequence 31, 0, 1.
//   6. mem[2]={6'd63,26'd0} -> after its handshake halted=1 and no reads for 10 cycles;
//      redirect to 0 -> halted=0, fetch resumes at 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/execute definitions: FSM state encoding, instruction field positions
// and the opcode map used by both the fetch and execute stages.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;

    // Field bit positions inside a 32-bit instruction word
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RD_MSB    = 25;
    localparam int RD_LSB    = 21;
    localparam int RS_MSB    = 20;
    localparam int RS_LSB    = 16;
    localparam int RT_MSB    = 15;
    localparam int RT_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_MSB  = 5;
    localparam int FUNC_LSB  = 0;
    localparam int IMM_MSB   = 15;
    localparam int JADDR_MSB = 25;

    localparam logic [5:0] OP_BR_FIRST = 6'd12;
    localparam logic [5:0] OP_BR_LAST  = 6'd24;
    localparam logic [5:0] OP_HALT     = 6'd63;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_CAPT  = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic is_branch_op(input logic [5:0] opcode);
        return (opcode >= OP_BR_FIRST) && (opcode <= OP_BR_LAST);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational slicer from an instruction word to its fixed fields;
// shared with the execute stage.
module instr_field_decode
    import instr_fetch_unit_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic [4:0]         rd,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         shamt,
    output logic [5:0]         func,
    output logic [15:0]        imm,
    output logic [25:0]        jaddr
);

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign func   = instr[FUNC_MSB:FUNC_LSB];
    assign imm    = instr[IMM_MSB:0];
    assign jaddr  = instr[JADDR_MSB:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads one word per fetch, presents it decoded over
// valid/ready and follows PC redirects from execute.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int               ADDR_W      = 5,
    parameter int               DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [5:0]       HALT_OPCODE = OP_HALT
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [5:0]        out_opcode,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_func,
    output logic [15:0]       out_imm,
    output logic [25:0]       out_jaddr,
    output logic              halted
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc;

    // A redirect in the issue cycle suppresses the strobe: that read would be wrong-path.
    always_comb begin
        state_n   = state;
        mem_rd_en = 1'b0;
        mem_addr  = pc;
        case (state)
            S_ISSUE: begin
                mem_rd_en = !reset && !redirect_valid;
                state_n   = S_CAPT;
            end
            S_CAPT:  state_n = S_HOLD;
            S_HOLD: begin
                if (out_ready) begin
                    state_n = (out_opcode == HALT_OPCODE) ? S_HALT : S_ISSUE;
                end
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_ISSUE;
        endcase
        if (redirect_valid) begin
            state_n = S_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_ISSUE;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            halted    <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else begin
            state <= state_n;
            if (redirect_valid) begin
                pc        <= redirect_pc;
                out_valid <= 1'b0;
                halted    <= 1'b0;
            end else begin
                case (state)
                    S_CAPT: begin
                        out_instr <= mem_rdata;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + ADDR_W'(1);
                    end
                    S_HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            halted    <= (out_opcode == HALT_OPCODE);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    instr_field_decode u_decode (
        .instr  (out_instr),
        .opcode (out_opcode),
        .rd     (out_rd),
        .rs     (out_rs),
        .rt     (out_rt),
        .shamt  (out_shamt),
        .func   (out_func),
        .imm    (out_imm),
        .jaddr  (out_jaddr)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized run
// scored against a transaction-level model of the fetched PC stream.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        mem_rd_en;
    logic [4:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [4:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [4:0]  out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_shamt;
    logic [5:0]  out_func;
    logic [15:0] out_imm;
    logic [25:0] out_jaddr;
    logic        halted;

    logic [31:0] mem [32];
    int          n_assert;
    int          n_fail;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_opcode     (out_opcode),
        .out_rd         (out_rd),
        .out_rs         (out_rs),
        .out_rt         (out_rt),
        .out_shamt      (out_shamt),
        .out_func       (out_func),
        .out_imm        (out_imm),
        .out_jaddr      (out_jaddr),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag, input logic [31:0] w);
        check({tag, ".opcode"}, 32'(out_opcode), w >> 26);
        check({tag, ".rd"},     32'(out_rd),     (w >> 21) & 32'h1F);
        check({tag, ".rs"},     32'(out_rs),     (w >> 16) & 32'h1F);
        check({tag, ".rt"},     32'(out_rt),     (w >> 11) & 32'h1F);
        check({tag, ".shamt"},  32'(out_shamt),  (w >> 6) & 32'h1F);
        check({tag, ".func"},   32'(out_func),   w & 32'h3F);
        check({tag, ".imm"},    32'(out_imm),    w & 32'hFFFF);
        check({tag, ".jaddr"},  32'(out_jaddr),  w & 32'h03FF_FFFF);
    endtask

    // Wait (bounded) at negedges for a presented word and check it is mem[p] from p.
    task automatic expect_present(input logic [4:0] p);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 20);
        if (!out_valid) begin
            check("present_timeout", 32'(out_valid), 32'd1);
        end else begin
            check("present.pc", 32'(out_pc), 32'(p));
            check("present.instr", out_instr, mem[p]);
            check_fields("present", mem[p]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0]  exp_pc;
        logic        prev_v;
        logic [31:0] prev_instr;
        logic [4:0]  prev_pc;
        logic [31:0] held;
        int          k;

        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            if (mem[i][31:26] == 6'd63) mem[i][31:26] = 6'd1;
        end
        mem[0] = 32'h3BFD_0001;

        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst.halted",    32'(halted),    32'd0);
        check("rst.out_instr", out_instr,      32'd0);
        check("rst.out_pc",    32'(out_pc),    32'd0);
        tick();
        reset = 1'b0;

        // Test 1: first fetch, two-cycle latency
        @(negedge clk);
        check("t1.c1.rd_en", 32'(mem_rd_en), 32'd1);
        check("t1.c1.addr",  32'(mem_addr),  32'd0);
        @(negedge clk);
        check("t1.c2.rd_en", 32'(mem_rd_en), 32'd0);
        check("t1.c2.valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t1.valid",  32'(out_valid),  32'd1);
        check("t1.pc",     32'(out_pc),     32'd0);
        check("t1.opcode", 32'(out_opcode), 32'd14);
        check("t1.rd",     32'(out_rd),     32'd31);
        check("t1.rs",     32'(out_rs),     32'd29);
        check("t1.imm",    32'(out_imm),    32'd1);
        check_fields("t1", 32'h3BFD_0001);

        // Test 2: backpressure holds everything stable
        held = out_instr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2.valid", 32'(out_valid), 32'd1);
            check("t2.instr", out_instr,      held);
            check("t2.rd_en", 32'(mem_rd_en), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t2.after.valid", 32'(out_valid), 32'd0);
        check("t2.after.rd_en", 32'(mem_rd_en), 32'd1);
        check("t2.after.addr",  32'(mem_addr),  32'd1);
        expect_present(5'd1);

        // Test 3: redirect during capture of word 4 discards it
        expect_present(5'd2);
        expect_present(5'd3);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(mem_rd_en && mem_addr == 5'd4) && k < 10);
        check("t3.issue4", 32'(mem_rd_en && mem_addr == 5'd4), 32'd1);
        tick();
        redirect_valid = 1'b1; redirect_pc = 5'd9;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t3.valid", 32'(out_valid), 32'd0);
        check("t3.addr",  32'(mem_addr),  32'd9);
        expect_present(5'd9);

        // Test 4: redirect wins over a same-cycle handshake
        redirect_valid = 1'b1; redirect_pc = 5'd20;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4.valid", 32'(out_valid), 32'd0);
        check("t4.addr",  32'(mem_addr),  32'd20);
        expect_present(5'd20);

        // Test 5: PC wraps 31 -> 0
        redirect_valid = 1'b1; redirect_pc = 5'd31;
        tick();
        redirect_valid = 1'b0;
        expect_present(5'd31);
        expect_present(5'd0);
        expect_present(5'd1);

        // Test 6: halt opcode stops fetching until a redirect
        mem[2] = {6'd63, 26'd0};
        expect_present(5'd2);
        @(negedge clk);
        check("t6.halted", 32'(halted),    32'd1);
        check("t6.valid",  32'(out_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6.no_rd", 32'(mem_rd_en), 32'd0);
            check("t6.hold_halt", 32'(halted), 32'd1);
        end
        tick();
        redirect_valid = 1'b1; redirect_pc = 5'd0;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t6.unhalt", 32'(halted),    32'd0);
        check("t6.rd_en",  32'(mem_rd_en), 32'd1);
        check("t6.addr",   32'(mem_addr),  32'd0);
        expect_present(5'd0);
        mem[2] = 32'h0123_4567;

        // Test 7: reset mid-operation beats a same-cycle redirect
        expect_present(5'd1);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'd17;
        tick();
        reset = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        check("t7.valid",  32'(out_valid), 32'd0);
        check("t7.halted", 32'(halted),    32'd0);
        check("t7.addr",   32'(mem_addr),  32'd0);
        expect_present(5'd0);

        // Randomized run against a model of the presented-PC stream
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_pc = 5'd0; prev_v = 1'b0; prev_instr = '0; prev_pc = '0;
        for (int i = 0; i < 600; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = 5'($urandom_range(0, 31));
            @(negedge clk);
            if (mem_rd_en) check("rnd.addr", 32'(mem_addr), 32'(exp_pc));
            check("rnd.rd_vs_valid", 32'(mem_rd_en && out_valid), 32'd0);
            if (out_valid && !prev_v) begin
                check("rnd.pc",    32'(out_pc), 32'(exp_pc));
                check("rnd.instr", out_instr,   mem[exp_pc]);
            end
            if (out_valid && prev_v) begin
                check("rnd.stable.instr", out_instr,   prev_instr);
                check("rnd.stable.pc",    32'(out_pc), 32'(prev_pc));
            end
            prev_v = out_valid; prev_instr = out_instr; prev_pc = out_pc;
            if (redirect_valid) exp_pc = redirect_pc;
            else if (out_valid && out_ready) exp_pc = exp_pc + 5'd1;
            tick();
        end
        redirect_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
